// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - shared encodings for the load/store initiator
package mem_access_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RMW_RD,
    ST_STORE,
    ST_RESP
  } state_e;

  // Little-endian byte lanes within a 32-bit word
  localparam logic [1:0] LANE_0 = 2'd0;
  localparam logic [1:0] LANE_1 = 2'd1;
  localparam logic [1:0] LANE_2 = 2'd2;
  localparam logic [1:0] LANE_3 = 2'd3;

endpackage

// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - datapath-side request/response bundle
interface mem_access_unit_if #(
  parameter int ADDR_W = 32
);
  logic              req;
  logic              we;
  logic [1:0]        size;
  logic              sign_ext;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              ready;
  logic              done;
  logic              err;
  logic [31:0]       rdata;

  modport master (
    output req, we, size, sign_ext, addr, wdata,
    input  ready, done, err, rdata
  );

  modport slave (
    input  req, we, size, sign_ext, addr, wdata,
    output ready, done, err, rdata
  );
endinterface

// File: rtl/mem_access_unit_lane_align.sv
// rtl/mem_access_unit_lane_align.sv - combinational lane extract and sub-word merge
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  size_e       size,
  input  logic        sign_ext,
  input  logic [31:0] wdata,
  output logic [31:0] load_val,
  output logic [31:0] merged
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[7:0];
    case (lane)
      LANE_0: byte_sel = word[7:0];
      LANE_1: byte_sel = word[15:8];
      LANE_2: byte_sel = word[23:16];
      LANE_3: byte_sel = word[31:24];
      default: byte_sel = word[7:0];
    endcase
    half_sel = (lane == LANE_2) ? word[31:16] : word[15:0];

    load_val = word;
    case (size)
      SZ_BYTE: load_val = sign_ext ? {{24{byte_sel[7]}}, byte_sel} : {24'd0, byte_sel};
      SZ_HALF: load_val = sign_ext ? {{16{half_sel[15]}}, half_sel} : {16'd0, half_sel};
      default: load_val = word;
    endcase
  end

  // Sub-word stores splice the new bytes into the word just read back
  always_comb begin
    merged = word;
    case (size)
      SZ_BYTE: begin
        case (lane)
          LANE_0: merged[7:0]   = wdata[7:0];
          LANE_1: merged[15:8]  = wdata[7:0];
          LANE_2: merged[23:16] = wdata[7:0];
          LANE_3: merged[31:24] = wdata[7:0];
          default: merged = word;
        endcase
      end
      SZ_HALF: begin
        if (lane == LANE_2) merged[31:16] = wdata[15:0];
        else                merged[15:0]  = wdata[15:0];
      end
      default: merged = wdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - byte/half/word load-store initiator in front of dataMemory
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int MEM_WORDS = 101
) (
  input  logic               clk,
  input  logic               reset_n,
  mem_access_unit_if.slave   cpu,
  output logic [31:0]        mem_address,
  output logic [31:0]        mem_data_in,
  output logic               mem_read,
  output logic               mem_write,
  input  logic [31:0]        mem_data_out
);

  state_e            state;
  size_e             l_size;
  logic              l_sext;
  logic [1:0]        l_lane;
  logic [31:0]       l_wdata;
  logic [ADDR_W-1:0] word_idx;
  logic              bad;
  logic [31:0]       load_val;
  logic [31:0]       merged;

  assign word_idx = cpu.addr >> 2;

  always_comb begin
    bad = 1'b0;
    if (size_e'(cpu.size) == SZ_ILL)                              bad = 1'b1;
    if (size_e'(cpu.size) == SZ_HALF && cpu.addr[0])              bad = 1'b1;
    if (size_e'(cpu.size) == SZ_WORD && cpu.addr[1:0] != 2'b00)   bad = 1'b1;
    if (word_idx >= ADDR_W'(MEM_WORDS))                           bad = 1'b1;
  end

  mem_lane_align u_align (
    .word     (mem_data_out),
    .lane     (l_lane),
    .size     (l_size),
    .sign_ext (l_sext),
    .wdata    (l_wdata),
    .load_val (load_val),
    .merged   (merged)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      l_size      <= SZ_BYTE;
      l_sext      <= 1'b0;
      l_lane      <= 2'd0;
      l_wdata     <= 32'd0;
      cpu.ready   <= 1'b1;
      cpu.done    <= 1'b0;
      cpu.err     <= 1'b0;
      cpu.rdata   <= 32'd0;
      mem_address <= 32'd0;
      mem_data_in <= 32'd0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cpu.req) begin
            l_size      <= size_e'(cpu.size);
            l_sext      <= cpu.sign_ext;
            l_lane      <= cpu.addr[1:0];
            l_wdata     <= cpu.wdata;
            mem_address <= 32'(word_idx);
            cpu.ready   <= 1'b0;
            if (bad) begin
              cpu.done <= 1'b1;
              cpu.err  <= 1'b1;
              state    <= ST_RESP;
            end else if (!cpu.we) begin
              mem_read <= 1'b1;
              state    <= ST_LOAD;
            end else if (size_e'(cpu.size) == SZ_WORD) begin
              mem_data_in <= cpu.wdata;
              mem_write   <= 1'b1;
              state       <= ST_STORE;
            end else begin
              mem_read <= 1'b1;
              state    <= ST_RMW_RD;
            end
          end
        end
        ST_LOAD: begin
          cpu.rdata <= load_val;
          mem_read  <= 1'b0;
          cpu.done  <= 1'b1;
          state     <= ST_RESP;
        end
        ST_RMW_RD: begin
          mem_data_in <= merged;
          mem_read    <= 1'b0;
          mem_write   <= 1'b1;
          state       <= ST_STORE;
        end
        ST_STORE: begin
          mem_write <= 1'b0;
          cpu.done  <= 1'b1;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          cpu.done  <= 1'b0;
          cpu.err   <= 1'b0;
          cpu.ready <= 1'b1;
          state     <= ST_IDLE;
        end
        default: begin
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
          cpu.done  <= 1'b0;
          cpu.err   <= 1'b0;
          cpu.ready <= 1'b1;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench with transaction-level model
module tb_mem_access_unit;

  localparam int ADDR_W    = 32;
  localparam int MEM_WORDS = 101;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        mem_init;
  logic [31:0] mem_address, mem_data_in, mem_data_out;
  logic        mem_read, mem_write;

  mem_access_unit_if #(.ADDR_W(ADDR_W)) cpu ();

  mem_access_unit #(.ADDR_W(ADDR_W), .MEM_WORDS(MEM_WORDS)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .cpu          (cpu),
    .mem_address  (mem_address),
    .mem_data_in  (mem_data_in),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_data_out (mem_data_out)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    if (i == 80) return 32'd8;
    if (i == 83) return 32'hFFFF_FF86;
    if (i == 84) return 32'hFFFF_FF38;
    return 32'hA500_0000 | 32'(i);
  endfunction

  // Environment dataMemory: combinational read, write on the edge
  logic [31:0] dmem [0:MEM_WORDS-1];
  always_comb begin
    mem_data_out = 32'd0;
    if (mem_address < 32'(MEM_WORDS)) mem_data_out = dmem[mem_address[6:0]];
  end
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < MEM_WORDS; i++) dmem[i] <= init_word(i);
    end else if (mem_write && mem_address < 32'(MEM_WORDS)) begin
      dmem[mem_address[6:0]] <= mem_data_in;
    end
  end

  // Reference model state
  logic [31:0] shadow [0:MEM_WORDS-1];
  logic [31:0] exp_rdata;
  logic [31:0] exp_idx;
  logic [31:0] exp_wword;

  int errors = 0;
  int checks = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req_v);
    end
  endtask

  // Per-cycle compare: any strobe must target the model's word and never overlap
  always @(negedge clk) begin
    if (reset_n && !mem_init && (mem_read || mem_write)) begin
      check("strobe_excl", 32'(mem_read & mem_write), 32'd0);
      check("strobe_addr", mem_address, exp_idx);
      if (mem_write) check("wr_data", mem_data_in, exp_wword);
    end
  end

  task automatic drive_idle();
    cpu.req = 1'b0; cpu.we = 1'b0; cpu.size = 2'b00; cpu.sign_ext = 1'b0;
    cpu.addr = '0; cpu.wdata = 32'd0;
  endtask

  task automatic access(input string nm, input logic w, input logic [1:0] sz,
                        input logic sx, input logic [31:0] a, input logic [31:0] wd,
                        input bit busy_pulse);
    logic        bad;
    int          lat, exp_rd, exp_wr;
    int          n_done, done_cyc, n_rd, n_wr;
    logic        err_seen;
    logic [31:0] rdata_seen, v, mask;
    int          sh;
    sh  = 8 * int'(a[1:0]);
    bad = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00)
          || ((a >> 2) >= 32'(MEM_WORDS));
    lat    = bad ? 1 : ((w && sz != 2'b10) ? 3 : 2);
    exp_rd = bad ? 0 : ((!w || sz != 2'b10) ? 1 : 0);
    exp_wr = (bad || !w) ? 0 : 1;
    exp_idx = a >> 2;
    if (!bad && !w) begin
      v = shadow[exp_idx] >> sh;
      if (sz == 2'b00) begin
        v = v & 32'hFF;
        if (sx && v[7]) v = v | 32'hFFFF_FF00;
      end else if (sz == 2'b01) begin
        v = v & 32'hFFFF;
        if (sx && v[15]) v = v | 32'hFFFF_0000;
      end
      exp_rdata = v;
    end
    if (!bad && w) begin
      if (sz == 2'b10) exp_wword = wd;
      else begin
        mask = ((sz == 2'b00) ? 32'hFF : 32'hFFFF) << sh;
        exp_wword = (shadow[exp_idx] & ~mask) | ((wd << sh) & mask);
      end
    end

    @(negedge clk);
    check({nm, "_ready"}, 32'(cpu.ready), 32'd1);
    cpu.req = 1'b1; cpu.we = w; cpu.size = sz; cpu.sign_ext = sx;
    cpu.addr = a; cpu.wdata = wd;
    n_done = 0; done_cyc = -1; n_rd = 0; n_wr = 0;
    err_seen = 1'b0; rdata_seen = 32'd0;
    for (int k = 1; k <= lat + 3; k++) begin
      @(negedge clk);
      cpu.req = 1'b0;
      if (busy_pulse && k == 1) begin
        cpu.req = 1'b1; cpu.we = 1'b1; cpu.size = 2'b10; cpu.addr = 32'h190;
      end
      if (mem_read) n_rd++;
      if (mem_write) n_wr++;
      if (cpu.done) begin
        n_done++;
        if (done_cyc < 0) begin
          done_cyc = k; err_seen = cpu.err; rdata_seen = cpu.rdata;
        end
      end
    end
    drive_idle();
    if (!bad && w) shadow[exp_idx] = exp_wword;

    check({nm, "_ndone"}, 32'(n_done), 32'd1);
    check({nm, "_lat"}, 32'(done_cyc), 32'(lat));
    check({nm, "_err"}, 32'(err_seen), 32'(bad));
    check({nm, "_rdata"}, rdata_seen, exp_rdata);
    check({nm, "_nrd"}, 32'(n_rd), 32'(exp_rd));
    check({nm, "_nwr"}, 32'(n_wr), 32'(exp_wr));
    if (!bad) check({nm, "_mem"}, dmem[exp_idx[6:0]], shadow[exp_idx]);
  endtask

  task automatic reset_abort();
    int n_done, n_wr;
    exp_idx = 32'd84;
    @(negedge clk);
    cpu.req = 1'b1; cpu.we = 1'b1; cpu.size = 2'b00; cpu.addr = 32'h150; cpu.wdata = 32'h55;
    @(negedge clk);
    drive_idle();
    check("abort_in_rmw", 32'(mem_read), 32'd1);
    reset_n = 1'b0;
    @(negedge clk);
    exp_rdata = 32'd0;
    check("abort_ready", 32'(cpu.ready), 32'd1);
    check("abort_done", 32'(cpu.done), 32'd0);
    check("abort_strobes", 32'({mem_read, mem_write}), 32'd0);
    check("abort_rdata", cpu.rdata, 32'd0);
    check("abort_wdata", mem_data_in, 32'd0);
    reset_n = 1'b1;
    n_done = 0; n_wr = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (cpu.done) n_done++;
      if (mem_write) n_wr++;
    end
    check("abort_no_done", 32'(n_done), 32'd0);
    check("abort_no_write", 32'(n_wr), 32'd0);
    check("abort_mem84", dmem[84], shadow[84]);
  endtask

  initial begin
    for (int i = 0; i < MEM_WORDS; i++) shadow[i] = init_word(i);
    exp_rdata = 32'd0; exp_idx = 32'd0; exp_wword = 32'd0;
    drive_idle();
    reset_n  = 1'b0;
    mem_init = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    mem_init = 1'b0;
    check("rst_ready", 32'(cpu.ready), 32'd1);
    check("rst_done_err", 32'({cpu.done, cpu.err}), 32'd0);
    check("rst_strobes", 32'({mem_read, mem_write}), 32'd0);
    check("rst_rdata", cpu.rdata, 32'd0);
    check("rst_mem_data_in", mem_data_in, 32'd0);
    check("rst_mem_address", mem_address, 32'd0);
    reset_n = 1'b1;

    access("lb_s", 1'b0, 2'b00, 1'b1, 32'h14C, 32'd0, 1'b0);
    check("lit_lb_s", cpu.rdata, 32'hFFFF_FF86);
    access("lb_u", 1'b0, 2'b00, 1'b0, 32'h14C, 32'd0, 1'b0);
    check("lit_lb_u", cpu.rdata, 32'h0000_0086);
    access("lw80", 1'b0, 2'b10, 1'b0, 32'h140, 32'd0, 1'b0);
    check("lit_lw80", cpu.rdata, 32'h0000_0008);
    check("lit_addr80", mem_address, 32'd80);
    access("sb141", 1'b1, 2'b00, 1'b0, 32'h141, 32'hAB, 1'b0);
    check("lit_merge", mem_data_in, 32'h0000_AB08);
    access("lw80b", 1'b0, 2'b10, 1'b0, 32'h140, 32'd0, 1'b0);
    check("lit_lw80b", cpu.rdata, 32'h0000_AB08);
    access("sh_mis", 1'b1, 2'b01, 1'b0, 32'h141, 32'h1234, 1'b0);
    check("lit_err_keep", cpu.rdata, 32'h0000_AB08);
    access("lw_oor", 1'b0, 2'b10, 1'b0, 32'h194, 32'd0, 1'b0);
    access("sw_oor", 1'b1, 2'b10, 1'b0, 32'h194, 32'h1111, 1'b0);
    access("sz_ill", 1'b0, 2'b11, 1'b0, 32'h140, 32'd0, 1'b0);
    access("lw_mis", 1'b0, 2'b10, 1'b0, 32'h142, 32'd0, 1'b0);
    access("lh_hi_s", 1'b0, 2'b01, 1'b1, 32'h14E, 32'd0, 1'b0);
    check("lit_lh_hi", cpu.rdata, 32'hFFFF_FFFF);
    access("lh_lo_u", 1'b0, 2'b01, 1'b0, 32'h14C, 32'd0, 1'b0);
    check("lit_lh_lo", cpu.rdata, 32'h0000_FF86);
    access("sw86", 1'b1, 2'b10, 1'b0, 32'h158, 32'hDEAD_BEEF, 1'b0);
    access("sh86", 1'b1, 2'b01, 1'b0, 32'h15A, 32'hFFFF_1234, 1'b0);
    check("lit_sh86", dmem[86], 32'h1234_BEEF);
    access("lb86_3", 1'b0, 2'b00, 1'b1, 32'h15B, 32'd0, 1'b0);
    check("lit_lb86_3", cpu.rdata, 32'h0000_0012);
    access("lb86_0", 1'b0, 2'b00, 1'b1, 32'h158, 32'd0, 1'b0);
    check("lit_lb86_0", cpu.rdata, 32'hFFFF_FFEF);
    access("sw100", 1'b1, 2'b10, 1'b0, 32'h190, 32'h0BAD_F00D, 1'b0);
    access("lw100", 1'b0, 2'b10, 1'b0, 32'h190, 32'd0, 1'b1);
    check("lit_lw100", cpu.rdata, 32'h0BAD_F00D);
    reset_abort();
    access("lw84", 1'b0, 2'b10, 1'b0, 32'h150, 32'd0, 1'b0);
    check("lit_lw84", cpu.rdata, 32'hFFFF_FF38);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store initiator that sits between the multicycle CPU control path and `dataMemory`. It accepts one byte, halfword or word access at a time from the datapath over a req/ready/done handshake. It converts the byte address to `dataMemory`'s word index and drives `memRead`/`memWrite`/`address`/`dataIn`. Sub-word stores use a read-modify-write sequence; sub-word loads are lane-extracted and zero- or sign-extended.

## Interface
Parameters:
- `ADDR_W`, default 32: width of the CPU byte address.
- `MEM_WORDS`, default 101: number of words in `dataMemory`. A word index greater than or equal to this is out of range.

Ports:
- `clk`, in, 1: the single clock. All state changes on the rising edge.
- `reset_n`, in, 1: synchronous, active-low reset.
- `req`, in, 1: access request. Sampled only when `ready`=1.
- `we`, in, 1: 1 = store, 0 = load.
- `size`, in, 2: 00 = byte, 01 = half, 10 = word, 11 = illegal.
- `sign_ext`, in, 1: selects sign extension for loads.
- `addr`, in, `ADDR_W`: byte address.
- `wdata`, in, 32: store data. Right-aligned for sub-word stores.
- `ready`, out, 1: unit is idle and can accept `req`.
- `done`, out, 1: one-cycle completion pulse.
- `err`, out, 1: valid with `done`. Signals misaligned access, illegal size, or out-of-range address.
- `rdata`, out, 32: load result. Valid from `done` until the next request is accepted.
- `mem_address`, out, 32: word index to `dataMemory.address`, equal to `addr[ADDR_W-1:2]`, zero-extended.
- `mem_data_in`, out, 32: drives `dataMemory.dataIn`.
- `mem_read`, out, 1: drives `dataMemory.memRead`.
- `mem_write`, out, 1: drives `dataMemory.memWrite`.
- `mem_data_out`, in, 32: from `dataMemory.dataOut`. Combinational, valid in the same cycle as `mem_read`.

## Operation
- States: IDLE, LOAD, RMW_RD, STORE, RESP.
- IDLE:
  - `ready`=1.
  - On `req`, latch `we`, `size`, `sign_ext`, `addr` and `wdata`.
  - Check the request:
    - Misaligned: half with `addr[0]`≠0, or word with `addr[1:0]`≠0.
    - `size`=11.
    - Word index ≥ `MEM_WORDS`.
  - Any check fails: go to RESP with the error flag set.
  - Otherwise:
    - Load: go to LOAD.
    - Word store: go to STORE.
    - Sub-word store: go to RMW_RD.
- LOAD:
  - `mem_read`=1.
  - Extract the lane selected by `addr[1:0]` from `mem_data_out`. Byte lanes are little-endian: lane 0 is bits 7:0.
  - Zero- or sign-extend to 32 bits per `sign_ext`, register into `rdata`, then go to RESP.
- RMW_RD:
  - `mem_read`=1.
  - Register the merged word into `mem_data_in`. The merged word is `mem_data_out` with the addressed byte or half replaced by the low byte or half of `wdata`.
  - Go to STORE.
- STORE:
  - `mem_write`=1.
  - `mem_data_in` = `wdata` for a word store, or the merged word for a sub-word store.
  - Go to RESP.
- RESP:
  - `done`=1; `err` is the latched error flag.
  - Always go to IDLE.
- `mem_read` and `mem_write` are never both 1.
- Neither is 1 outside LOAD, RMW_RD and STORE.
- An errored request never asserts either strobe.
- `rdata` is unchanged by stores and by errored requests.

## Timing
- Request accepted in cycle 0. `done` appears at:
  - cycle 2: load or word store.
  - cycle 3: sub-word store.
  - cycle 1: error.
- Back-to-back: `ready` returns in the cycle after `done`. Minimum issue interval is 3 cycles for loads and word stores, 4 for sub-word stores.
- The memory write commits on the clock edge that ends STORE, so it is visible to a load that enters LOAD two or more cycles later.
- `req` while `ready`=0 is ignored. It is not queued.
- Reset values (`reset_n`=0 at an edge):
  - State becomes IDLE.
  - `ready`=1; `done`, `err`, `mem_read`, `mem_write` = 0.
  - `rdata`, `mem_data_in`, `mem_address` = 0.
- Reset mid-operation, including in RMW_RD or STORE, aborts with no `done`. A store aborted before its STORE edge leaves memory unchanged.
- Outputs are registered or decoded from the state register only.
- The sole combinational path is `mem_data_out` to the capture registers.

## Structure
- Package `mem_access_pkg` holds:
  - the `size` encodings (BYTE, HALF, WORD);
  - the state enum;
  - the lane-select constants.
- Sub-module `mem_lane_align` is purely combinational and provides:
  - load-side lane extract plus zero/sign extension;
  - store-side merge of a sub-word into a 32-bit word.
- The top level keeps the FSM and the registers.

## Test plan
- Signed byte load: `dataMemory` preloaded with word 83 = -122 (0xFFFFFF86); byte load, `sign_ext`=1, `addr`=0x14C → `done` at cycle 2, `rdata`=0xFFFFFF86. Repeat with `sign_ext`=0 → `rdata`=0x00000086.
- Word load: `addr`=0x140 (word 80 = 8) → `rdata`=0x00000008, one `mem_read` cycle, `mem_address`=80.
- Sub-word store (RMW): byte store `wdata`=0xAB at 0x141 → RMW_RD, then STORE with `mem_data_in`=0x0000AB08, `done` at cycle 3. A following word load of 0x140 returns 0x0000AB08.
- Errors: half store at 0x141, and any access at 0x194 (word 101 ≥ `MEM_WORDS`) → `done`+`err` at cycle 1, `mem_write` never asserted, `rdata` unchanged.
- Reset abort: drive `reset_n` low during RMW_RD of a byte store to word 84 → IDLE next cycle, no `done`, word 84 still -200.
- Busy handshake: pulse `req` during LOAD → ignored. Exactly one `done`, and no extra memory strobes.
